// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter that shares one multi-cycle divider among
// NUM_REQ requesters. One operation is in flight at a time. Completion is
// timed by a latency counter; the divider's done output is not used.
// Optional feature macro: DIV_ARBITER_ZERO_BYPASS_EN (zero divisor answered
// locally with quotient all-ones and remainder = dividend, divider not started).
module div_arbiter #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DIV_LATENCY = DATA_WIDTH + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]            req_sign_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_quot_o,
  output logic [DATA_WIDTH-1:0]         rsp_rem_o,
  output logic                          div_start_o,
  output logic [DATA_WIDTH-1:0]         div_in1_o,
  output logic [DATA_WIDTH-1:0]         div_in2_o,
  output logic                          div_sign_o,
  input  logic [DATA_WIDTH-1:0]         div_quot_i,
  input  logic [DATA_WIDTH-1:0]         div_rem_i
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]         last_grant_q, last_grant_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_quot_q, rsp_quot_d;
  logic [DATA_WIDTH-1:0]   rsp_rem_q, rsp_rem_d;
  logic                    div_start_q, div_start_d;
  logic [DATA_WIDTH-1:0]   div_in1_q, div_in1_d;
  logic [DATA_WIDTH-1:0]   div_in2_q, div_in2_d;
  logic                    div_sign_q, div_sign_d;

  logic                    found;
  logic [ID_W-1:0]         winner;
  logic [ID_W-1:0]         cand;
  logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];

  // Unpack the flat operand buses into per-requester words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[g] = req_b_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting one past the last grant.
  always_comb begin
    found  = 1'b0;
    winner = last_grant_q;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Accept is combinational and only offered while idle.
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && found) req_ready_o[winner] = 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_quot_d   = rsp_quot_q;
    rsp_rem_d    = rsp_rem_q;
    div_in1_d    = div_in1_q;
    div_in2_d    = div_in2_q;
    div_sign_d   = div_sign_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          last_grant_d = winner;
          rsp_id_d     = winner;
          div_in1_d    = a_arr[winner];
          div_in2_d    = b_arr[winner];
          div_sign_d   = req_sign_i[winner];
          state_d      = S_ISSUE;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
          if (b_arr[winner] == '0) begin
            rsp_quot_d = '1;
            rsp_rem_d  = a_arr[winner];
            state_d    = S_RESP;
          end
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(DIV_LATENCY - 1)) begin
          rsp_quot_d = div_quot_i;
          rsp_rem_d  = div_rem_i;
          state_d    = S_RESP;
        end else if (cnt_q < CNT_W'(DIV_LATENCY)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    div_start_d = (state_d == S_ISSUE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      div_start_q  <= 1'b0;
      div_in1_q    <= '0;
      div_in2_q    <= '0;
      div_sign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_quot_q   <= rsp_quot_d;
      rsp_rem_q    <= rsp_rem_d;
      div_start_q  <= div_start_d;
      div_in1_q    <= div_in1_d;
      div_in2_q    <= div_in2_d;
      div_sign_q   <= div_sign_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_quot_o  = rsp_quot_q;
  assign rsp_rem_o   = rsp_rem_q;
  assign div_start_o = div_start_q;
  assign div_in1_o   = div_in1_q;
  assign div_in2_o   = div_in2_q;
  assign div_sign_o  = div_sign_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed table-driven bench for div_arbiter with a latency
// modelled divider (outputs garbage until DIV_LATENCY edges after div_start).
module tb_div_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;
  localparam int unsigned L  = DW + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a = '0;
  logic [NR*DW-1:0]  req_b = '0;
  logic [NR-1:0]     req_sign = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_quot, rsp_rem;
  logic              div_start;
  logic [DW-1:0]     div_in1, div_in2;
  logic              div_sign;
  logic [DW-1:0]     div_quot, div_rem;

  div_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DIV_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sign_i(req_sign),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_quot_o(rsp_quot), .rsp_rem_o(rsp_rem),
    .div_start_o(div_start), .div_in1_o(div_in1), .div_in2_o(div_in2),
    .div_sign_o(div_sign), .div_quot_i(div_quot), .div_rem_i(div_rem)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: result appears L-1 edges after the start sample edge,
  // computed from the live inputs (so input instability shows up).
  int dcnt = 0;
  bit running = 1'b0;
  always @(posedge clk) begin
    if (div_start) begin
      dcnt    <= 0;
      running <= 1'b1;
    end else if (running && dcnt < 1000) begin
      dcnt <= dcnt + 1;
    end
  end

  logic [DW-1:0] mq, mr;
  always_comb begin
    mq = '1;
    mr = div_in1;
    if (div_in2 != '0) begin
      if (div_sign) begin
        mq = DW'($signed(div_in1) / $signed(div_in2));
        mr = DW'($signed(div_in1) % $signed(div_in2));
      end else begin
        mq = div_in1 / div_in2;
        mr = div_in1 % div_in2;
      end
    end
    div_quot = (running && dcnt >= int'(L) - 1) ? mq : 32'hDEAD_BEEF;
    div_rem  = (running && dcnt >= int'(L) - 1) ? mr : 32'hBAAD_F00D;
  end

  // Protocol monitor: counts starts, tracks div_in stability and idle-only accept.
  int starts = 0, issue_cyc = 0, stab_err = 0, rr_err = 0;
  bit in_flight = 1'b0;
  logic [DW-1:0] s_in1, s_in2;
  logic s_sign;
  always @(negedge clk) begin
    if (div_start) begin
      starts++;
      issue_cyc = cyc;
      in_flight = 1'b1;
      s_in1 = div_in1; s_in2 = div_in2; s_sign = div_sign;
    end else if (in_flight && !rsp_valid && rst_n) begin
      if (div_in1 !== s_in1 || div_in2 !== s_in2 || div_sign !== s_sign) stab_err++;
    end
    if ((in_flight || rsp_valid) && req_ready != '0) rr_err++;
    if (rsp_valid || !rst_n) in_flight = 1'b0;
  end

  typedef struct {
    logic [NR-1:0] mask;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          s;
    int unsigned   id;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Non-winning slots carry distinct junk so a wrong slice select is visible.
  task automatic drive_req(input logic [NR-1:0] mask, input int unsigned id,
                           input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    for (int j = 0; j < int'(NR); j++) begin
      req_a[j*DW +: DW] = 32'h1000 + 32'(j) * 32'd17;
      req_b[j*DW +: DW] = 32'd3;
      req_sign[j]       = 1'b0;
    end
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
    req_sign[id]       = s;
    req_valid          = mask;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready == '0 && n < 50) begin tick(); n++; end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic apply_op(input vec_t v);
    int acc_cyc;
    bit byp = 1'b0;
`ifdef DIV_ARBITER_ZERO_BYPASS_EN
    byp = (v.b == '0);
`endif
    tick();
    starts = 0; stab_err = 0;
    drive_req(v.mask, v.id, v.a, v.b, v.s);
    #1;
    wait_ready();
    chk("grant", 64'(req_ready), 64'(4'b0001 << v.id));
    acc_cyc = cyc;
    tick();
    req_valid = '0;
    wait_rsp();
    if (byp) begin
      chk("bypass_latency", 64'(cyc - acc_cyc), 64'd1);
      chk("bypass_starts", 64'(starts), 64'd0);
    end else begin
      chk("latency", 64'(cyc - issue_cyc), 64'(L + 1));
      chk("starts", 64'(starts), 64'd1);
    end
    chk("rsp_id", 64'(rsp_id), 64'(v.id));
    chk("rsp_quot", 64'(rsp_quot), 64'(v.q));
    chk("rsp_rem", 64'(rsp_rem), 64'(v.r));
    chk("div_in_stable", 64'(stab_err), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish by 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int bp_err, n;
    logic [DW-1:0] hq, hr;
    logic [1:0] hid;

    vt[0] = '{4'b0001, 32'd100,        32'd7,          1'b0, 0, 32'd14,         32'd2};
    vt[1] = '{4'b0001, 32'hFFFF_FF9C,  32'd7,          1'b1, 0, 32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vt[2] = '{4'b0001, 32'd55,         32'd0,          1'b0, 0, 32'hFFFF_FFFF,  32'd55};
    vt[3] = '{4'b1111, 32'd1000,       32'd10,         1'b0, 1, 32'd100,        32'd0};
    vt[4] = '{4'b1111, 32'hFFFF_FFFF,  32'd2,          1'b0, 2, 32'h7FFF_FFFF,  32'd1};
    vt[5] = '{4'b1111, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 3, 32'd3,          32'hFFFF_FFFF};
    vt[6] = '{4'b1111, 32'd50,         32'd5,          1'b0, 0, 32'd10,         32'd0};
    vt[7] = '{4'b1010, 32'd9,          32'd4,          1'b0, 1, 32'd2,          32'd1};
    vt[8] = '{4'b1001, 32'd20,         32'd6,          1'b1, 3, 32'd3,          32'd2};
    vt[9] = '{4'b0001, 32'h8000_0000,  32'd1,          1'b1, 0, 32'h8000_0000,  32'd0};

    // Reset values.
    tick();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_div_start", 64'(div_start), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_quot", 64'(rsp_quot), 64'd0);
    chk("rst_rsp_rem", 64'(rsp_rem), 64'd0);
    chk("rst_div_in", {div_in1, div_in2}, 64'd0);
    chk("rst_div_sign", 64'(div_sign), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 10; k++) apply_op(vt[k]);

    // Backpressure with all requesters held valid (last grant is 0 here).
    tick();
    starts = 0;
    drive_req(4'b1111, 1, 32'd101, 32'd3, 1'b0);
    #1;
    wait_ready();
    chk("bp_grant", 64'(req_ready), 64'b0010);
    tick();
    wait_rsp();
    chk("bp_id", 64'(rsp_id), 64'd1);
    chk("bp_quot", 64'(rsp_quot), 64'd33);
    chk("bp_rem", 64'(rsp_rem), 64'd2);
    hid = rsp_id; hq = rsp_quot; hr = rsp_rem;
    bp_err = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!rsp_valid || rsp_id !== hid || rsp_quot !== hq || rsp_rem !== hr || req_ready != '0)
        bp_err++;
    end
    chk("bp_hold", 64'(bp_err), 64'd0);
    chk("bp_starts", 64'(starts), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_drop", 64'(rsp_valid), 64'd0);
    chk("bp_next_grant", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    wait_rsp();
    chk("bp2_id", 64'(rsp_id), 64'd2);
    chk("bp2_quot", 64'(rsp_quot), 64'h560);
    chk("bp2_rem", 64'(rsp_rem), 64'd2);
    chk("bp2_starts", 64'(starts), 64'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset in the middle of WAIT, counter at 10.
    tick();
    drive_req(4'b0100, 2, 32'd100, 32'd7, 1'b0);
    #1;
    wait_ready();
    tick();
    req_valid = '0;
    n = 0;
    while (cyc != issue_cyc + 11 && n < 60) begin tick(); n++; end
    chk("mid_wait_reached", 64'(cyc - issue_cyc), 64'd11);
    rst_n = 1'b0;
    #1;
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_div_start", 64'(div_start), 64'd0);
    chk("mr_rsp_fields", {30'd0, rsp_id, rsp_quot}, 64'd0);
    chk("mr_rsp_rem", 64'(rsp_rem), 64'd0);
    chk("mr_div_in", {div_in1, div_in2}, 64'd0);
    chk("mr_div_sign", 64'(div_sign), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    starts = 0;
    bp_err = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (rsp_valid) bp_err++;
    end
    chk("mr_no_rsp", 64'(bp_err), 64'd0);
    chk("mr_no_start", 64'(starts), 64'd0);
    apply_op(vt[0]);

    chk("ready_only_idle", 64'(rr_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
